// File: rtl/tick_rate_pkg.sv
// Shared constants for the tick rate detector: rate codes, nominal periods
// derived from the divider's divide values, and the detector FSM state type.
package tick_rate_pkg;

  localparam logic [1:0] RATE_NORMAL  = 2'd0;
  localparam logic [1:0] RATE_FAST0   = 2'd1;
  localparam logic [1:0] RATE_FAST1   = 2'd2;
  localparam logic [1:0] RATE_UNKNOWN = 2'd3;

  // Divider toggles every DIV+1 cycles, so a full tick period is 2*(DIV+1).
  localparam int DIV_NORMAL = 25000;
  localparam int DIV_FAST0  = 416;
  localparam int DIV_FAST1  = 6;

  localparam int NOM_PERIOD_NORMAL = 2 * (DIV_NORMAL + 1);
  localparam int NOM_PERIOD_FAST0  = 2 * (DIV_FAST0 + 1);
  localparam int NOM_PERIOD_FAST1  = 2 * (DIV_FAST1 + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

endpackage

// File: rtl/tick_edge_sync.sv
// Brings the asynchronous tick into clkin and emits a one-cycle rising-edge strobe.
// Define TICK_DEGLITCH_EN to add a two-sample agreement filter (one extra cycle).
module tick_edge_sync (
  input  logic clkin,
  input  logic rst_N,
  input  logic d_async,
  output logic edge_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_edge;
  logic w_level;

  // Stage 1-2: two-flop synchronizer
  always_ff @(posedge clkin or negedge rst_N) begin
    if (!rst_N) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= d_async;
      r_sync2 <= r_sync1;
    end
  end

`ifdef TICK_DEGLITCH_EN
  logic r_filt;

  // Level only moves once two consecutive synced samples agree
  always_ff @(posedge clkin or negedge rst_N) begin
    if (!rst_N) begin
      r_filt <= 1'b0;
    end else if (r_sync1 == r_sync2) begin
      r_filt <= r_sync2;
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync2;
`endif

  // Final stage: registered rising-edge detect
  always_ff @(posedge clkin or negedge rst_N) begin
    if (!rst_N) begin
      r_prev <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_prev <= w_level;
      r_edge <= w_level & ~r_prev;
    end
  end

  assign edge_pulse = r_edge;

endmodule

// File: rtl/tick_rate_detector.sv
// Measures the rising-to-rising period of a divided tick and locks onto its rate.
// TICK_DEGLITCH_EN (see tick_edge_sync) adds a debounce and one cycle of edge latency.
module tick_rate_detector
  import tick_rate_pkg::*;
#(
  parameter int CNT_W         = 17,
  parameter int PERIOD_NORMAL = NOM_PERIOD_NORMAL,
  parameter int PERIOD_FAST0  = NOM_PERIOD_FAST0,
  parameter int PERIOD_FAST1  = NOM_PERIOD_FAST1,
  parameter int TOL           = 4,
  parameter int LOCK_CNT      = 2,
  parameter int TIMEOUT       = 100000
) (
  input  logic             clkin,
  input  logic             rst_N,
  input  logic             tick_in,
  output logic [1:0]       rate,
  output logic             locked,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             lost
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic within_tol(input logic [CNT_W:0] p, input int nom);
    int d;
    d = int'(p) - nom;
    return (d <= TOL) && (d >= -TOL);
  endfunction

  function automatic logic [1:0] classify(input logic [CNT_W:0] p);
    if (within_tol(p, PERIOD_NORMAL)) return RATE_NORMAL;
    if (within_tol(p, PERIOD_FAST0))  return RATE_FAST0;
    if (within_tol(p, PERIOD_FAST1))  return RATE_FAST1;
    return RATE_UNKNOWN;
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_cand;
  logic [1:0]         w_cand_nxt;
  logic [MATCH_W-1:0] r_match;
  logic [MATCH_W-1:0] w_match_nxt;
  logic [1:0]         r_rate;
  logic [1:0]         w_rate_nxt;
  logic               r_locked;
  logic               w_locked_nxt;
  logic [CNT_W-1:0]   r_period;
  logic               r_meas_valid;
  logic               r_lost;
  logic               w_lost_nxt;

  logic               w_edge;
  logic [CNT_W:0]     w_meas;
  logic [1:0]         w_class;
  logic               w_timeout;
  logic               w_meas_fire;

  tick_edge_sync u_sync (
    .clkin      (clkin),
    .rst_N      (rst_N),
    .d_async    (tick_in),
    .edge_pulse (w_edge)
  );

  assign w_meas      = {1'b0, r_cnt} + (CNT_W + 1)'(1);
  assign w_class     = classify(w_meas);
  assign w_meas_fire = w_edge && (r_state != ST_IDLE);
  // An edge landing on the timeout cycle counts as a measurement, not a loss
  assign w_timeout   = (r_state != ST_IDLE) && !w_edge && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_cand_nxt   = r_cand;
    w_match_nxt  = r_match;
    w_rate_nxt   = r_rate;
    w_locked_nxt = r_locked;
    w_lost_nxt   = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_edge) begin
          w_state_nxt = ST_MEASURE;
          w_match_nxt = '0;
          w_cand_nxt  = RATE_UNKNOWN;
        end
      end
      ST_MEASURE: begin
        if (w_edge) begin
          if (w_class == RATE_UNKNOWN) begin
            w_match_nxt = '0;
          end else if (w_class == r_cand) begin
            w_match_nxt = r_match + MATCH_W'(1);
          end else begin
            w_cand_nxt  = w_class;
            w_match_nxt = MATCH_W'(1);
          end
          if (int'(w_match_nxt) >= LOCK_CNT) begin
            w_state_nxt  = ST_LOCKED;
            w_rate_nxt   = w_cand_nxt;
            w_locked_nxt = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (w_edge && (w_class != r_rate)) begin
          w_state_nxt  = ST_MEASURE;
          w_locked_nxt = 1'b0;
          w_rate_nxt   = RATE_UNKNOWN;
          if (w_class != RATE_UNKNOWN) begin
            w_cand_nxt  = w_class;
            w_match_nxt = MATCH_W'(1);
          end else begin
            w_match_nxt = '0;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_timeout) begin
      w_state_nxt  = ST_IDLE;
      w_locked_nxt = 1'b0;
      w_rate_nxt   = RATE_UNKNOWN;
      w_lost_nxt   = 1'b1;
    end
  end

  // Register stage: state, counter and all outputs
  always_ff @(posedge clkin or negedge rst_N) begin
    if (!rst_N) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_cand       <= RATE_UNKNOWN;
      r_match      <= '0;
      r_rate       <= RATE_UNKNOWN;
      r_locked     <= 1'b0;
      r_period     <= '0;
      r_meas_valid <= 1'b0;
      r_lost       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= (r_state == ST_IDLE || w_edge || w_timeout) ? '0 : sat_inc(r_cnt);
      r_cand       <= w_cand_nxt;
      r_match      <= w_match_nxt;
      r_rate       <= w_rate_nxt;
      r_locked     <= w_locked_nxt;
      r_meas_valid <= w_meas_fire;
      r_lost       <= w_lost_nxt;
      if (w_meas_fire) begin
        r_period <= w_meas[CNT_W-1:0];
      end
    end
  end

  assign rate       = r_rate;
  assign locked     = r_locked;
  assign period     = r_period;
  assign meas_valid = r_meas_valid;
  assign lost       = r_lost;

endmodule

// File: tb/tb_tick_rate_detector.sv
// Randomized bench for tick_rate_detector against an event-level reference model;
// nominal periods and timeout are scaled down to keep the run short.
module tb_tick_rate_detector;

  localparam int CNT_W    = 12;
  localparam int P_NORMAL = 202;
  localparam int P_FAST0  = 54;
  localparam int P_FAST1  = 14;
  localparam int TOL      = 4;
  localparam int LOCK_CNT = 2;
  localparam int TIMEOUT  = 400;
`ifdef TICK_DEGLITCH_EN
  localparam bit DEGLITCH = 1'b1;
`else
  localparam bit DEGLITCH = 1'b0;
`endif

  logic             clkin = 1'b0;
  logic             rst_N = 1'b0;
  logic             tick_in = 1'b0;
  logic [1:0]       rate;
  logic             locked;
  logic [CNT_W-1:0] period;
  logic             meas_valid;
  logic             lost;

  tick_rate_detector #(
    .CNT_W         (CNT_W),
    .PERIOD_NORMAL (P_NORMAL),
    .PERIOD_FAST0  (P_FAST0),
    .PERIOD_FAST1  (P_FAST1),
    .TOL           (TOL),
    .LOCK_CNT      (LOCK_CNT),
    .TIMEOUT       (TIMEOUT)
  ) dut (
    .clkin      (clkin),
    .rst_N      (rst_N),
    .tick_in    (tick_in),
    .rate       (rate),
    .locked     (locked),
    .period     (period),
    .meas_valid (meas_valid),
    .lost       (lost)
  );

  always #5 clkin = ~clkin;

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;

  // Reference model state: strobes are kept as the sample index at which
  // their effect must be visible on the outputs.
  int strobe_q[$];
  bit filt    = 1'b0;
  bit hprev   = 1'b0;
  bit armed   = 1'b0;
  int last    = 0;
  int cand    = 3;
  int match   = 0;
  int exp_rate   = 3;
  int exp_locked = 0;
  int exp_period = 0;
  int exp_mv     = 0;
  int exp_lost   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at sample %0d: got %0d, expected %0d", tag, k, got, exp);
    end
  endtask

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int classify(input int p);
    if (absdiff(p, P_NORMAL) <= TOL) return 0;
    if (absdiff(p, P_FAST0)  <= TOL) return 1;
    if (absdiff(p, P_FAST1)  <= TOL) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    strobe_q.delete();
    filt = 1'b0; hprev = 1'b0; armed = 1'b0;
    cand = 3; match = 0; last = 0;
    exp_rate = 3; exp_locked = 0; exp_period = 0; exp_mv = 0; exp_lost = 0;
  endtask

  task automatic model_step();
    int c;
    exp_mv   = 0;
    exp_lost = 0;
    if (strobe_q.size() > 0 && strobe_q[0] == k) begin
      void'(strobe_q.pop_front());
      if (!armed) begin
        armed = 1'b1; cand = 3; match = 0;
      end else begin
        exp_period = k - last;
        exp_mv     = 1;
        c = classify(exp_period);
        if (exp_locked != 0) begin
          if (c != exp_rate) begin
            exp_locked = 0; exp_rate = 3;
            if (c != 3) begin cand = c; match = 1; end
            else match = 0;
          end
        end else begin
          if (c == 3) match = 0;
          else if (c == cand) match = match + 1;
          else begin cand = c; match = 1; end
          if (match >= LOCK_CNT) begin exp_locked = 1; exp_rate = cand; end
        end
      end
      last = k;
    end else if (armed && k == last + TIMEOUT) begin
      armed = 1'b0; exp_locked = 0; exp_rate = 3; exp_lost = 1;
    end
  endtask

  task automatic model_drive(input bit v);
    if (DEGLITCH) begin
      if (v == hprev && v != filt) begin
        filt = v;
        if (v) strobe_q.push_back(k + 4);
      end
    end else if (v != filt) begin
      filt = v;
      if (v) strobe_q.push_back(k + 4);
    end
    hprev = v;
  endtask

  task automatic check_outputs();
    check_val("meas_valid", int'(meas_valid), exp_mv);
    check_val("lost",       int'(lost),       exp_lost);
    check_val("period",     int'(period),     exp_period);
    check_val("rate",       int'(rate),       exp_rate);
    check_val("locked",     int'(locked),     exp_locked);
  endtask

  task automatic tick_cycle(input bit v);
    @(negedge clkin);
    k++;
    model_step();
    check_outputs();
    tick_in = v;
    model_drive(v);
  endtask

  task automatic drive_period(input int p, input int hi);
    for (int i = 0; i < hi; i++) tick_cycle(1'b1);
    for (int i = 0; i < p - hi; i++) tick_cycle(1'b0);
  endtask

  task automatic repeat_period(input int n, input int p);
    for (int i = 0; i < n; i++) drive_period(p, p / 2);
  endtask

  // Reset is asserted mid-cycle so the asynchronous clear is observed before any clock edge.
  task automatic do_reset(input int cycles);
    #2 rst_N = 1'b0;
    tick_in = 1'b0;
    #1;
    model_reset();
    check_outputs();
    for (int i = 0; i < cycles; i++) tick_cycle(1'b0);
    rst_N = 1'b1;
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) tick_cycle(1'b0);
    rst_N = 1'b1;
    for (int i = 0; i < 5; i++) tick_cycle(1'b0);

    // Fast-1 lock, then normal, then fast-0
    repeat_period(4, 14);
    repeat_period(4, P_NORMAL);
    repeat_period(4, P_FAST0);
    // Switch from fast-0 to fast-1: drop lock then relock
    repeat_period(3, 14);
    // Tolerance edge: 18 still matches, 19 does not
    repeat_period(3, 18);
    repeat_period(3, 19);
    // Out-of-band period never locks
    repeat_period(5, 20);

    // Stall with tick low, then recover
    repeat_period(4, 14);
    for (int i = 0; i < TIMEOUT + 20; i++) tick_cycle(1'b0);
    repeat_period(4, 14);

    // Gap equal to the timeout is a measurement; one more cycle is a loss
    drive_period(TIMEOUT, 7);
    drive_period(TIMEOUT + 1, 7);
    repeat_period(4, 14);

    // Reset during measurement with a rise still in the synchronizer
    repeat_period(2, 14);
    tick_cycle(1'b1);
    tick_cycle(1'b1);
    do_reset(3);
    for (int i = 0; i < 6; i++) tick_cycle(1'b0);

    // Single-cycle glitches
    for (int g = 0; g < 3; g++) begin
      tick_cycle(1'b1);
      for (int i = 0; i < 15; i++) tick_cycle(1'b0);
    end
    repeat_period(3, 14);

    // Randomized segments around each nominal, arbitrary periods, and timeout gaps
    for (int s = 0; s < 30; s++) begin
      int sel;
      int p;
      int reps;
      sel  = int'($urandom_range(0, 5));
      reps = int'($urandom_range(1, 4));
      case (sel)
        0:       p = P_NORMAL + int'($urandom_range(0, 12)) - 6;
        1:       p = P_FAST0 + int'($urandom_range(0, 12)) - 6;
        2, 3:    p = P_FAST1 + int'($urandom_range(0, 12)) - 6;
        4:       p = int'($urandom_range(6, 260));
        default: begin p = TIMEOUT - 1 + int'($urandom_range(0, 3)); reps = 1; end
      endcase
      for (int r = 0; r < reps; r++) drive_period(p, int'($urandom_range(2, p - 2)));
    end

    for (int i = 0; i < 20; i++) tick_cycle(1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
